// File: rtl/bus_slot_sequencer.sv
// Time-multiplexed bus slot generator: rotates through the enabled slots, DIV clocks each,
// producing per-slot enables, latch strobes, frame pulses and a heartbeat LED toggle.
module bus_slot_sequencer #(
  parameter int NUM_SLOTS = 3,
  parameter int DIV       = 4,
  parameter int HB_WIDTH  = 23
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         stall,
  input  logic [NUM_SLOTS-1:0]         slot_mask,
  output logic [NUM_SLOTS-1:0]         slot_en,
  output logic [NUM_SLOTS-1:0]         slot_strobe,
  output logic [$clog2(NUM_SLOTS)-1:0] slot_idx,
  output logic                         frame_start,
  output logic                         heartbeat
);

  localparam int IW = $clog2(NUM_SLOTS);
  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t              state;
  logic [CW-1:0]       div_cnt;
  logic [HB_WIDTH-1:0] frame_cnt;
  logic [IW-1:0]       first_idx;
  logic [IW-1:0]       adv_idx;
  logic                slot_last;
  logic                advance;
  logic                start_frame;

  // Round-robin search beginning just after cur; cur itself is the last candidate.
  function automatic logic [IW-1:0] search_from(input logic [IW-1:0] cur,
                                                 input logic [NUM_SLOTS-1:0] mask);
    logic [IW-1:0] res;
    logic          found;
    int            j;
    res   = cur;
    found = 1'b0;
    for (int k = 1; k <= NUM_SLOTS; k++) begin
      j = (int'(cur) + k) % NUM_SLOTS;
      if (!found && mask[IW'(j)]) begin
        res   = IW'(j);
        found = 1'b1;
      end
    end
    return res;
  endfunction

  function automatic logic [NUM_SLOTS-1:0] onehot(input logic [IW-1:0] idx);
    return NUM_SLOTS'(1) << idx;
  endfunction

  assign first_idx   = search_from(IW'(NUM_SLOTS - 1), slot_mask);
  assign adv_idx     = search_from(slot_idx, slot_mask);
  assign slot_last   = (state == RUN) && (div_cnt == LAST) && !stall;
  assign advance     = slot_last && (|slot_mask);
  assign start_frame = ((state == IDLE) && (|slot_mask)) ||
                       (advance && (adv_idx <= slot_idx));
  assign slot_strobe = slot_en & {NUM_SLOTS{(div_cnt == LAST) && !stall}};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      div_cnt     <= '0;
      slot_idx    <= '0;
      slot_en     <= '0;
      frame_start <= 1'b0;
      frame_cnt   <= '0;
      heartbeat   <= 1'b0;
    end else begin
      frame_start <= start_frame;
      if (start_frame) begin
        frame_cnt <= frame_cnt + HB_WIDTH'(1);
        if (&frame_cnt)
          heartbeat <= ~heartbeat;
      end
      case (state)
        IDLE: begin
          if (|slot_mask) begin
            state    <= RUN;
            slot_idx <= first_idx;
            slot_en  <= onehot(first_idx);
            div_cnt  <= '0;
          end
        end
        RUN: begin
          if (!stall) begin
            if (div_cnt != LAST) begin
              div_cnt <= div_cnt + CW'(1);
            end else begin
              div_cnt <= '0;
              // The mask is only consulted here, so the running slot always completes.
              if (|slot_mask) begin
                slot_idx <= adv_idx;
                slot_en  <= onehot(adv_idx);
              end else begin
                state    <= IDLE;
                slot_idx <= '0;
                slot_en  <= '0;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_slot_sequencer.sv
// Directed self-checking bench for bus_slot_sequencer: default rotation, masking, stall,
// empty mask, async reset and heartbeat (second instance with small DIV/HB_WIDTH).
module tb_bus_slot_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       stall;
  logic [2:0] slot_mask;
  logic [2:0] slot_en;
  logic [2:0] slot_strobe;
  logic [1:0] slot_idx;
  logic       frame_start;
  logic       heartbeat;

  logic       hb_stall = 1'b0;
  logic [2:0] hb_mask  = 3'b001;
  logic [2:0] hb_slot_en;
  logic [2:0] hb_slot_strobe;
  logic [1:0] hb_slot_idx;
  logic       hb_frame_start;
  logic       hb_heartbeat;

  int tests_run    = 0;
  int tests_failed = 0;

  bus_slot_sequencer #(.NUM_SLOTS(3), .DIV(4), .HB_WIDTH(23)) dut (
    .clk(clk), .reset(reset), .stall(stall), .slot_mask(slot_mask),
    .slot_en(slot_en), .slot_strobe(slot_strobe), .slot_idx(slot_idx),
    .frame_start(frame_start), .heartbeat(heartbeat)
  );

  bus_slot_sequencer #(.NUM_SLOTS(3), .DIV(2), .HB_WIDTH(2)) dut_hb (
    .clk(clk), .reset(reset), .stall(hb_stall), .slot_mask(hb_mask),
    .slot_en(hb_slot_en), .slot_strobe(hb_slot_strobe), .slot_idx(hb_slot_idx),
    .frame_start(hb_frame_start), .heartbeat(hb_heartbeat)
  );

  always #5 clk = ~clk;

  // Reset is released on a falling edge, so the next rising edge is "edge 0".
  task apply_reset(input logic [2:0] m);
    @(negedge clk);
    reset     = 1'b1;
    stall     = 1'b0;
    slot_mask = m;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task test_default_sequence(input string tag);
    logic [8:0] obs, exp;
    logic [1:0] e_idx;
    logic [2:0] e_en;
    for (int n = 1; n <= 13; n++) begin
      @(posedge clk);
      @(negedge clk);
      e_idx = (n == 13) ? 2'd0 : 2'((n - 1) / 4);
      e_en  = 3'b001 << e_idx;
      exp   = {e_en, ((n % 4 == 0) && (n <= 12)) ? e_en : 3'b000,
               (n == 1 || n == 13), e_idx};
      obs   = {slot_en, slot_strobe, frame_start, slot_idx};
      tests_run++;
      if (obs !== exp) begin
        tests_failed++;
        $display("[TB] FAIL %s clk %0d {en,strobe,fs,idx} got %b exp %b", tag, n, obs, exp);
      end
    end
  endtask

  task test_reset();
    reset     = 1'b1;
    stall     = 1'b0;
    slot_mask = 3'b111;
    @(negedge clk);
    tests_run++;
    if ({slot_en, slot_strobe, slot_idx, frame_start, heartbeat, hb_heartbeat} !== 11'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_state got %b exp %b",
               {slot_en, slot_strobe, slot_idx, frame_start, heartbeat, hb_heartbeat}, 11'b0);
    end
    reset = 1'b0;
    test_default_sequence("default");
  endtask

  task test_mask();
    logic [8:0] obs, exp;
    logic [1:0] e_idx;
    logic [2:0] e_en;
    logic       e_fs;
    apply_reset(3'b101);
    for (int n = 1; n <= 21; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (n <= 16) begin
        e_idx = (((n - 1) / 4) % 2 == 1) ? 2'd2 : 2'd0;
        e_fs  = ((n - 1) % 8 == 0);
      end else begin
        e_idx = 2'd1;
        e_fs  = (n == 17 || n == 21);
      end
      e_en = 3'b001 << e_idx;
      exp  = {e_en, (n % 4 == 0) ? e_en : 3'b000, e_fs, e_idx};
      obs  = {slot_en, slot_strobe, frame_start, slot_idx};
      tests_run++;
      if (obs !== exp) begin
        tests_failed++;
        $display("[TB] FAIL mask clk %0d {en,strobe,fs,idx} got %b exp %b", n, obs, exp);
      end
      if (n == 14)
        slot_mask = 3'b010;
    end
  endtask

  task test_stall();
    logic [5:0] obs, exp;
    logic [2:0] e_en;
    apply_reset(3'b111);
    for (int n = 1; n <= 15; n++) begin
      @(posedge clk);
      #1 stall = (n >= 7 && n <= 9);
      @(negedge clk);
      e_en = (n <= 4) ? 3'b001 : (n <= 11) ? 3'b010 : 3'b100;
      exp  = {e_en, (n == 4 || n == 11 || n == 15) ? e_en : 3'b000};
      obs  = {slot_en, slot_strobe};
      tests_run++;
      if (obs !== exp) begin
        tests_failed++;
        $display("[TB] FAIL stall_mid clk %0d {en,strobe} got %b exp %b", n, obs, exp);
      end
    end
    stall = 1'b0;
  endtask

  task test_stall_on_strobe();
    logic [5:0] obs, exp;
    logic [2:0] e_en;
    apply_reset(3'b111);
    for (int n = 1; n <= 9; n++) begin
      @(posedge clk);
      #1 stall = (n == 4);
      @(negedge clk);
      e_en = (n <= 5) ? 3'b001 : 3'b010;
      exp  = {e_en, (n == 5 || n == 9) ? e_en : 3'b000};
      obs  = {slot_en, slot_strobe};
      tests_run++;
      if (obs !== exp) begin
        tests_failed++;
        $display("[TB] FAIL stall_strobe clk %0d {en,strobe} got %b exp %b", n, obs, exp);
      end
    end
    stall = 1'b0;
  endtask

  task test_empty_mask();
    logic [6:0] obs, exp;
    logic [2:0] e_en;
    apply_reset(3'b111);
    for (int n = 1; n <= 13; n++) begin
      @(posedge clk);
      @(negedge clk);
      e_en = (n <= 4) ? 3'b001 : (n <= 8) ? 3'b010 : (n <= 11) ? 3'b000 : 3'b100;
      exp  = {e_en, (n == 4 || n == 8) ? e_en : 3'b000, (n == 1 || n == 12)};
      obs  = {slot_en, slot_strobe, frame_start};
      tests_run++;
      if (obs !== exp) begin
        tests_failed++;
        $display("[TB] FAIL empty_mask clk %0d {en,strobe,fs} got %b exp %b", n, obs, exp);
      end
      if (n == 6)
        slot_mask = 3'b000;
      if (n == 11)
        slot_mask = 3'b100;
    end
  endtask

  task test_async_reset();
    apply_reset(3'b111);
    for (int n = 1; n <= 9; n++)
      @(posedge clk);
    #1;
    tests_run++;
    if (slot_en !== 3'b100) begin
      tests_failed++;
      $display("[TB] FAIL async_pre slot_en got %b exp %b", slot_en, 3'b100);
    end
    #1 reset = 1'b1;
    #1;
    tests_run++;
    if ({slot_en, slot_strobe, slot_idx, frame_start, heartbeat} !== 10'b0) begin
      tests_failed++;
      $display("[TB] FAIL async_reset got %b exp %b",
               {slot_en, slot_strobe, slot_idx, frame_start, heartbeat}, 10'b0);
    end
    @(negedge clk);
    reset = 1'b0;
    test_default_sequence("after_reset");
  endtask

  task test_heartbeat();
    logic [4:0] obs, exp;
    apply_reset(3'b111);
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk);
      @(negedge clk);
      exp = {3'b001, (n % 2 == 1), (n >= 7 && n < 15)};
      obs = {hb_slot_en, hb_frame_start, hb_heartbeat};
      tests_run++;
      if (obs !== exp) begin
        tests_failed++;
        $display("[TB] FAIL heartbeat clk %0d {en,fs,hb} got %b exp %b", n, obs, exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_mask();
    test_stall();
    test_stall_on_strobe();
    test_empty_mask();
    test_async_reset();
    test_heartbeat();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
